// File: rtl/core_fetch_queue_if.sv
// Bundles every signal of the fetch queue except clock and reset.
//   run, flush, flush_pc          : fetch enable and redirect (core -> queue)
//   mem_val, mem_addr             : read request to instruction memory (queue -> mem)
//   mem_rdy, mem_rdata            : read accept and data, same cycle (mem -> queue)
//   instr_val, instr, instr_pc    : head entry offered to decode (queue -> decode)
//   instr_rdy                     : decode consumes the head (decode -> queue)
//   count, fetch_pc               : occupancy and current fetch PC (debug/status)
// Modport "slave" is the queue's view; "master" is the surrounding core/memory view.
interface core_fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 8,
    parameter int DW    = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          run;
    logic          flush;
    logic [AW-1:0] flush_pc;
    logic          mem_val;
    logic [AW-1:0] mem_addr;
    logic          mem_rdy;
    logic [DW-1:0] mem_rdata;
    logic          instr_val;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_rdy;
    logic [CW-1:0] count;
    logic [AW-1:0] fetch_pc;

    modport slave (
        input  run, flush, flush_pc, mem_rdy, mem_rdata, instr_rdy,
        output mem_val, mem_addr, instr_val, instr, instr_pc, count, fetch_pc
    );

    modport master (
        output run, flush, flush_pc, mem_rdy, mem_rdata, instr_rdy,
        input  mem_val, mem_addr, instr_val, instr, instr_pc, count, fetch_pc
    );
endinterface

// File: rtl/core_fetch_queue.sv
// Instruction prefetch queue.
// Walks a fetch PC, issues val/rdy reads to instruction memory, buffers each
// returned word together with its PC in a DEPTH-entry FIFO and offers the head
// entry to decode with a valid/ready handshake. A flush discards the queue and
// reloads the fetch PC.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous reset, active high
//   bus  : core_fetch_queue_if.slave (memory port, decode port, control, status)
module core_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 8,
    parameter int DW    = 16
) (
    input  logic               clk,
    input  logic               rst,
    core_fetch_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] RESET_PC = AW'(8'h10);

    logic [AW-1:0] fetch_pc_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    logic [AW-1:0] slot_pc   [DEPTH];
    logic [DW-1:0] slot_data [DEPTH];

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

    // The request is built only from registered state, run and flush, so the
    // memory side never sees a combinational path from the decode handshake.
    // rst is folded in so the request drops the instant reset asserts.
    assign bus.mem_val  = bus.run & ~bus.flush & ~full & ~rst;
    assign bus.mem_addr = fetch_pc_reg;
    assign push         = bus.mem_val & bus.mem_rdy;
    assign pop          = ~empty & bus.instr_rdy & ~bus.flush;

    // Pointer, occupancy and fetch PC state. A flush wins over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_reg <= RESET_PC;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else if (bus.flush) begin
            fetch_pc_reg <= bus.flush_pc;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg   <= wr_ptr_reg + 1'b1;
                fetch_pc_reg <= fetch_pc_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    // Storage slots. Contents need no reset: the outputs are masked while the
    // queue is empty, and a slot is always written before it becomes visible.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [AW-1:0] pc_reg;
            logic [DW-1:0] data_reg;

            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PW'(gi))) begin
                    pc_reg   <= fetch_pc_reg;
                    data_reg <= bus.mem_rdata;
                end
            end

            assign slot_pc[gi]   = pc_reg;
            assign slot_data[gi] = data_reg;
        end
    endgenerate

    // Head entry read straight from storage so a word pushed in one cycle is
    // offered to decode in the next. Zero while empty (including reset).
    assign bus.instr_val = ~empty;
    assign bus.instr     = empty ? '0 : slot_data[rd_ptr_reg];
    assign bus.instr_pc  = empty ? '0 : slot_pc[rd_ptr_reg];
    assign bus.count     = count_reg;
    assign bus.fetch_pc  = fetch_pc_reg;
endmodule

// File: tb/tb_core_fetch_queue.sv
// Self-checking bench for core_fetch_queue: directed scenarios followed by a
// randomized run, all compared against a queue-based reference model.
module tb_core_fetch_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 8;
    localparam int DW    = 16;

    logic clk;
    logic rst;

    core_fetch_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    core_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Instruction memory image: word at address a is 16'h1000 + a.
    assign bus.mem_rdata = 16'h1000 + {8'h00, bus.mem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_step = 0;

    // Reference model: ordered list of {pc, instr} entries and the fetch PC.
    logic [23:0] mq [$];
    logic [7:0]  mpc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, check outputs against the model at the
    // falling edge, then advance the model by the rules of the queue.
    task automatic step(input bit r, input bit f, input logic [7:0] fp,
                        input bit mr, input bit ir);
        bit          ev;
        logic [23:0] hd;
        bus.run       = r;
        bus.flush     = f;
        bus.flush_pc  = fp;
        bus.mem_rdy   = mr;
        bus.instr_rdy = ir;
        @(negedge clk);
        ev = r && !f && (mq.size() < DEPTH);
        check("mem_val",   32'(bus.mem_val),   32'(ev));
        check("mem_addr",  32'(bus.mem_addr),  32'(mpc));
        check("fetch_pc",  32'(bus.fetch_pc),  32'(mpc));
        check("count",     32'(bus.count),     32'(mq.size()));
        check("instr_val", 32'(bus.instr_val), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            hd = mq[0];
            check("instr_pc", 32'(bus.instr_pc), 32'(hd[23:16]));
            check("instr",    32'(bus.instr),    32'(hd[15:0]));
        end
        $display("step %0d run=%0b flush=%0b mrdy=%0b irdy=%0b addr=%h cnt=%0d head_pc=%h",
                 n_step, r, f, mr, ir, bus.mem_addr, bus.count, bus.instr_pc);
        n_step++;
        if (f) begin
            mq.delete();
            mpc = fp;
        end else begin
            if (mq.size() != 0 && ir) void'(mq.pop_front());
            if (ev && mr) begin
                mq.push_back({mpc, 16'h1000 + {8'h00, mpc}});
                mpc = mpc + 8'h01;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges, checked before release.
    task automatic pulse_reset(input string tag);
        bus.run       = 1'b0;
        bus.flush     = 1'b0;
        bus.mem_rdy   = 1'b0;
        bus.instr_rdy = 1'b0;
        #2 rst = 1'b1;
        bus.run = 1'b1;
        #1;
        check({tag, "_instr_val"}, 32'(bus.instr_val), 32'd0);
        check({tag, "_mem_val"},   32'(bus.mem_val),   32'd0);
        check({tag, "_count"},     32'(bus.count),     32'd0);
        check({tag, "_fetch_pc"},  32'(bus.fetch_pc),  32'h10);
        check({tag, "_instr"},     32'(bus.instr),     32'd0);
        check({tag, "_instr_pc"},  32'(bus.instr_pc),  32'd0);
        $display("reset pulse %s", tag);
        mq.delete();
        mpc = 8'h10;
        bus.run = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.run       = 1'b0;
        bus.flush     = 1'b0;
        bus.flush_pc  = '0;
        bus.mem_rdy   = 1'b0;
        bus.instr_rdy = 1'b0;
        mpc           = 8'h10;
        @(posedge clk);
        #1;

        // Power-on reset state, run already high.
        pulse_reset("por");

        // 1: streaming with both sides ready.
        for (int i = 0; i < 8; i++) step(1, 0, 8'h00, 1, 1);

        // 2: decode stalled until full, then one pop and a refill.
        pulse_reset("rst2");
        for (int i = 0; i < 6; i++) step(1, 0, 8'h00, 1, 0);
        step(1, 0, 8'h00, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 1, 0);

        // 3: fill PCs 20..22, flush to 40 with memory ready.
        step(0, 1, 8'h20, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 1, 0);
        step(1, 1, 8'h40, 1, 0);
        step(0, 0, 8'h00, 1, 0);
        step(1, 0, 8'h00, 1, 1);

        // 4: address wrap from FE.
        step(1, 1, 8'hFE, 1, 1);
        for (int i = 0; i < 6; i++) step(1, 0, 8'h00, 1, 1);

        // 5: memory stalls with decode ready.
        pulse_reset("rst5");
        step(1, 0, 8'h00, 1, 1);
        step(1, 0, 8'h00, 0, 1);
        step(1, 0, 8'h00, 0, 1);
        step(1, 0, 8'h00, 1, 1);
        step(1, 0, 8'h00, 1, 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 4) != 0), ($urandom_range(0, 19) == 0),
                 8'($urandom), ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6));
        end

        // 6: reset mid-cycle with three entries buffered.
        step(1, 1, 8'h80, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 1, 0);
        check("pre_rst6_count", 32'(bus.count), 32'd3);
        pulse_reset("rst6");
        for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
